// File: rtl/branch_resolve_unit_if.sv
// Execute-stage branch resolution bus: EX-side resolution inputs plus the
// registered predictor training/redirect packet.
interface branch_resolve_unit_if #(
    parameter int unsigned GHR_W = 8
);

    typedef struct packed {
        logic             PC_Vaild;
        logic [2:0]       BranchType;
        logic [31:0]      Target;
        logic [1:0]       TBT_Counter;
        logic [1:0]       GHR_Counter;
        logic [1:0]       CPHT;
        logic [GHR_W-1:0] GHR;
        logic [GHR_W-1:0] Recover_GHR;
    } Predict_Branch_S;

    typedef struct packed {
        logic             PC_Vaild;
        logic [31:0]      Update_PC;
        logic [31:0]      Update_Target;
        logic             PC_Taken;
        logic [2:0]       BranchType;
        logic [2:0]       Predict_BranchType;
        logic             Update_Location;
        logic [1:0]       TBT_Counter;
        logic [1:0]       GHR_Counter;
        logic [1:0]       CPHT;
        logic [GHR_W-1:0] GHR;
        logic [GHR_W-1:0] Recover_GHR;
        logic             PC_MissPredict;
        logic             Update_True_PC;
    } Update_Branch_S;

    logic            ex_valid;
    logic [31:0]     ex_pc;
    logic [2:0]      ex_type;
    logic            ex_taken;
    logic [31:0]     ex_target;
    Predict_Branch_S ex_pred;
    logic            ds_present;
    logic            stall;
    logic            flush;
    logic            busy;
    Update_Branch_S  Update_Predict;

    modport master (
        output ex_valid, ex_pc, ex_type, ex_taken, ex_target, ex_pred,
        output ds_present, stall, flush,
        input  busy, Update_Predict
    );

    modport slave (
        input  ex_valid, ex_pc, ex_type, ex_taken, ex_target, ex_pred,
        input  ds_present, stall, flush,
        output busy, Update_Predict
    );

endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves EX control-flow instructions against their fetch-time prediction, emits one
// training packet per resolution and holds mispredict redirects until the delay slot is in.
module branch_resolve_unit #(
    parameter int unsigned GHR_W = 8
) (
    input logic                  clk,
    input logic                  reset,
    branch_resolve_unit_if.slave bus
);

    localparam logic [2:0] BrNone   = 3'd0;
    localparam logic [2:0] BrBranch = 3'd1;

    typedef struct packed {
        logic             PC_Vaild;
        logic [31:0]      Update_PC;
        logic [31:0]      Update_Target;
        logic             PC_Taken;
        logic [2:0]       BranchType;
        logic [2:0]       Predict_BranchType;
        logic             Update_Location;
        logic [1:0]       TBT_Counter;
        logic [1:0]       GHR_Counter;
        logic [1:0]       CPHT;
        logic [GHR_W-1:0] GHR;
        logic [GHR_W-1:0] Recover_GHR;
        logic             PC_MissPredict;
        logic             Update_True_PC;
    } update_t;

    typedef enum logic [0:0] {StIdle, StWaitDs} state_e;

    state_e      state_q, state_d;
    update_t     upd_q, upd_d;
    update_t     pend_q, pend_d;
    update_t     pkt;
    logic [1:0]  sel_ctr;
    logic        pt;
    logic        mp;
    logic [31:0] ctgt;

    // Resolution: predicted direction, correct next PC and the packet it produces.
    always_comb begin
        sel_ctr = (bus.ex_pred.CPHT < 2'd2) ? bus.ex_pred.GHR_Counter : bus.ex_pred.TBT_Counter;
        pt      = bus.ex_pred.PC_Vaild &&
                  ((bus.ex_pred.BranchType != BrBranch) || (sel_ctr >= 2'd2));
        ctgt    = bus.ex_taken ? bus.ex_target : (bus.ex_pc + 32'd8);
        if (bus.ex_type == BrNone) begin
            mp = bus.ex_pred.PC_Vaild;
        end else begin
            mp = (pt != bus.ex_taken) ||
                 (bus.ex_taken && (bus.ex_pred.Target != bus.ex_target));
        end

        pkt                    = '0;
        pkt.PC_Vaild           = 1'b1;
        pkt.Update_PC          = bus.ex_pc;
        pkt.Update_Target      = ctgt;
        pkt.PC_Taken           = bus.ex_taken;
        pkt.BranchType         = bus.ex_type;
        pkt.Predict_BranchType = bus.ex_pred.BranchType;
        pkt.Update_Location    = bus.ex_pc[2];
        pkt.TBT_Counter        = bus.ex_pred.TBT_Counter;
        pkt.GHR_Counter        = bus.ex_pred.GHR_Counter;
        pkt.CPHT               = bus.ex_pred.CPHT;
        pkt.GHR                = bus.ex_pred.GHR;
        pkt.Recover_GHR        = {bus.ex_pred.Recover_GHR[GHR_W-2:0], bus.ex_taken};
        pkt.PC_MissPredict     = mp;
        pkt.Update_True_PC     = mp;
    end

    // Output defaults to zero so PC_Vaild is always a one-cycle pulse.
    always_comb begin
        state_d = state_q;
        upd_d   = '0;
        pend_d  = pend_q;
        if (bus.flush) begin
            state_d = StIdle;
            pend_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.ex_valid && !bus.stall) begin
                        if (!mp || bus.ds_present) begin
                            upd_d = pkt;
                        end else begin
                            pend_d  = pkt;
                            state_d = StWaitDs;
                        end
                    end
                end
                StWaitDs: begin
                    if (bus.ds_present) begin
                        upd_d   = pend_q;
                        pend_d  = '0;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            upd_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            upd_q   <= upd_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.busy           = (state_q == StWaitDs);
    assign bus.Update_Predict = upd_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized scoreboard bench for branch_resolve_unit: a spec-level model queues the
// expected packet per cycle and an independent monitor compares what the DUT emits.
module tb_branch_resolve_unit;

    localparam int unsigned GHR_W = 8;
    localparam logic [2:0] BrNone = 3'd0, BrBranch = 3'd1, BrCall = 3'd2;
    localparam int KNone = 0, KZero = 1, KPkt = 2;

    typedef struct packed {
        logic             PC_Vaild;
        logic [2:0]       BranchType;
        logic [31:0]      Target;
        logic [1:0]       TBT_Counter;
        logic [1:0]       GHR_Counter;
        logic [1:0]       CPHT;
        logic [GHR_W-1:0] GHR;
        logic [GHR_W-1:0] Recover_GHR;
    } pred_t;

    typedef struct packed {
        logic             PC_Vaild;
        logic [31:0]      Update_PC;
        logic [31:0]      Update_Target;
        logic             PC_Taken;
        logic [2:0]       BranchType;
        logic [2:0]       Predict_BranchType;
        logic             Update_Location;
        logic [1:0]       TBT_Counter;
        logic [1:0]       GHR_Counter;
        logic [1:0]       CPHT;
        logic [GHR_W-1:0] GHR;
        logic [GHR_W-1:0] Recover_GHR;
        logic             PC_MissPredict;
        logic             Update_True_PC;
    } upd_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [2:0]  typ;
        logic        taken;
        logic [31:0] tgt;
        pred_t       pred;
        logic        ds;
        logic        stall;
        logic        flush;
    } in_t;

    typedef struct {
        int   kind;
        upd_t pkt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    upd_t pend_q[$];   // model's single pending redirect (empty when not waiting)
    upd_t last_pkt = '0;

    branch_resolve_unit_if #(.GHR_W(GHR_W)) bus ();

    branch_resolve_unit #(.GHR_W(GHR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic upd_t ref_pkt(input in_t d);
        upd_t        r;
        int          ctr;
        bit          pt, mp;
        ctr = (d.pred.CPHT < 2) ? int'(d.pred.GHR_Counter) : int'(d.pred.TBT_Counter);
        pt  = d.pred.PC_Vaild && (d.pred.BranchType != BrBranch || ctr >= 2);
        if (d.typ == BrNone) mp = d.pred.PC_Vaild;
        else mp = (pt != d.taken) || (d.taken && d.pred.Target != d.tgt);
        r                    = '0;
        r.PC_Vaild           = 1'b1;
        r.Update_PC          = d.pc;
        r.Update_Target      = d.taken ? d.tgt : d.pc + 32'd8;
        r.PC_Taken           = d.taken;
        r.BranchType         = d.typ;
        r.Predict_BranchType = d.pred.BranchType;
        r.Update_Location    = ((d.pc >> 2) & 32'd1) != 0;
        r.TBT_Counter        = d.pred.TBT_Counter;
        r.GHR_Counter        = d.pred.GHR_Counter;
        r.CPHT               = d.pred.CPHT;
        r.GHR                = d.pred.GHR;
        r.Recover_GHR        = GHR_W'((int'(d.pred.Recover_GHR) * 2 + int'(d.taken)) % (1 << GHR_W));
        r.PC_MissPredict     = mp;
        r.Update_True_PC     = mp;
        return r;
    endfunction

    function automatic in_t idle_in();
        in_t d;
        d = '0;
        return d;
    endfunction

    function automatic in_t rand_in();
        in_t d;
        d.valid              = ($urandom % 10) < 7;
        d.pc                 = $urandom & 32'hFFFF_FFFC;
        d.typ                = 3'($urandom_range(4));
        d.taken              = (d.typ >= BrCall) ? 1'b1 : (d.typ == BrNone) ? 1'b0 : 1'($urandom);
        d.tgt                = $urandom & 32'hFFFF_FFFC;
        d.pred.PC_Vaild      = ($urandom % 4) != 0;
        d.pred.BranchType    = ($urandom % 2 != 0) ? d.typ : 3'($urandom_range(4));
        d.pred.Target        = ($urandom % 3 != 0) ? d.tgt : ($urandom & 32'hFFFF_FFFC);
        d.pred.TBT_Counter   = 2'($urandom);
        d.pred.GHR_Counter   = 2'($urandom);
        d.pred.CPHT          = 2'($urandom);
        d.pred.GHR           = GHR_W'($urandom);
        d.pred.Recover_GHR   = GHR_W'($urandom);
        d.ds                 = ($urandom % 10) < 6;
        d.stall              = ($urandom % 10) < 2;
        d.flush              = ($urandom % 25) == 0;
        return d;
    endfunction

    // One cycle: check busy, drive inputs, queue what the next edge must produce.
    task automatic cycle(input in_t d);
        exp_t e;
        upd_t p;
        @(negedge clk);
        chk("busy", 128'(bus.busy), 128'(pend_q.size() != 0));
        bus.ex_valid   = d.valid;
        bus.ex_pc      = d.pc;
        bus.ex_type    = d.typ;
        bus.ex_taken   = d.taken;
        bus.ex_target  = d.tgt;
        bus.ex_pred    = d.pred;
        bus.ds_present = d.ds;
        bus.stall      = d.stall;
        bus.flush      = d.flush;
        e.kind = KNone;
        e.pkt  = '0;
        if (d.flush) begin
            pend_q.delete();
            e.kind = KZero;
        end else if (pend_q.size() != 0) begin
            if (d.ds) begin
                e.kind = KPkt;
                e.pkt  = pend_q.pop_front();
            end
        end else if (d.valid && !d.stall) begin
            p = ref_pkt(d);
            if (!p.PC_MissPredict || d.ds) begin
                e.kind = KPkt;
                e.pkt  = p;
            end else begin
                pend_q.push_back(p);
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic async_reset();
        exp_t e;
        @(negedge clk);
        bus.ex_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.ds_present = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_reset_busy", 128'(bus.busy), 128'(0));
        chk("async_reset_packet", 128'(bus.Update_Predict), 128'(0));
        pend_q.delete();
        e.kind = KZero;
        e.pkt  = '0;
        exp_q.push_back(e);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectation.
    initial begin
        exp_t e;
        upd_t got;
        forever begin
            @(posedge clk);
            #1;
            got = bus.Update_Predict;
            if (got.PC_Vaild) last_pkt = got;
            if (exp_q.size() == 0) begin
                if (got.PC_Vaild) chk("unexpected_packet", 128'(got.PC_Vaild), 128'(0));
            end else begin
                e = exp_q.pop_front();
                if (e.kind == KPkt) chk("packet", 128'(got), 128'(e.pkt));
                else if (e.kind == KZero) chk("zero_packet", 128'(got), 128'(0));
                else chk("no_pulse", 128'(got.PC_Vaild), 128'(0));
            end
        end
    end

    initial begin
        in_t d;
        reset = 1'b1;
        bus.ex_valid = 1'b0; bus.ex_pc = '0; bus.ex_type = '0; bus.ex_taken = 1'b0;
        bus.ex_target = '0; bus.ex_pred = '0; bus.ds_present = 1'b0; bus.stall = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_busy", 128'(bus.busy), 128'(0));
        chk("reset_packet", 128'(bus.Update_Predict), 128'(0));
        reset = 1'b0;

        // Taken conditional hit
        d = idle_in();
        d.valid = 1; d.pc = 32'hBFC0_0010; d.typ = BrBranch; d.taken = 1; d.tgt = 32'hBFC0_0100;
        d.pred.PC_Vaild = 1; d.pred.BranchType = BrBranch; d.pred.Target = 32'hBFC0_0100;
        d.pred.GHR_Counter = 2'd3; d.ds = 1;
        cycle(d);
        cycle(idle_in());
        chk("hit_target", 128'(last_pkt.Update_Target), 128'(32'hBFC0_0100));
        chk("hit_mp", 128'(last_pkt.PC_MissPredict), 128'(0));

        // Direction mispredict, then same with the delay slot late by 3 cycles
        d.pc = 32'hBFC0_0014; d.tgt = 32'hBFC0_0200; d.pred.Target = 32'hBFC0_0200;
        d.pred.GHR_Counter = 2'd1;
        cycle(d);
        cycle(idle_in());
        chk("dir_mp", 128'(last_pkt.Update_True_PC), 128'(1));
        chk("dir_loc", 128'(last_pkt.Update_Location), 128'(1));
        d.ds = 0;
        cycle(d);
        d.valid = 0;
        cycle(d); cycle(d); cycle(d);
        d.ds = 1;
        cycle(d);
        cycle(idle_in());

        // False BTB hit
        d = idle_in();
        d.valid = 1; d.pc = 32'hBFC0_0020; d.typ = BrNone; d.pred.PC_Vaild = 1;
        d.pred.BranchType = BrBranch; d.pred.GHR_Counter = 2'd3; d.ds = 1;
        cycle(d);
        cycle(idle_in());
        chk("false_hit_target", 128'(last_pkt.Update_Target), 128'(32'hBFC0_0028));

        // History shift and PC wrap
        d = idle_in();
        d.valid = 1; d.pc = 32'hFFFF_FFFC; d.typ = BrBranch; d.taken = 0;
        d.pred.PC_Vaild = 1; d.pred.BranchType = BrBranch; d.pred.Recover_GHR = 8'hA5; d.ds = 1;
        cycle(d);
        cycle(idle_in());
        chk("wrap_ghr", 128'(last_pkt.Recover_GHR), 128'(8'h4A));
        chk("wrap_target", 128'(last_pkt.Update_Target), 128'(32'h0000_0004));

        // Flush coincident with ds_present while waiting; then async reset while waiting
        d = idle_in();
        d.valid = 1; d.pc = 32'hBFC0_0030; d.typ = BrBranch; d.taken = 1; d.tgt = 32'hBFC0_0400;
        d.pred.PC_Vaild = 1; d.pred.BranchType = BrBranch; d.pred.Target = 32'hBFC0_0400;
        cycle(d);
        d.valid = 0; d.ds = 1; d.flush = 1;
        cycle(d);
        d.flush = 0;
        cycle(d);
        d.valid = 1; d.ds = 0;
        cycle(d);
        d.valid = 0;
        cycle(d);
        async_reset();

        for (int i = 0; i < 3000; i++) cycle(rand_in());
        d = idle_in();
        d.ds = 1;
        cycle(d); cycle(d); cycle(d);
        @(negedge clk);
        chk("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-stage block that closes the prediction loop for `Branch_Predict`. It compares each resolved control-flow instruction against the prediction packet carried down the pipeline, then emits one registered `Update_Branch_S` packet per resolution to train the BTB/PHT. On a misprediction it raises a front-end redirect, holding the redirect until the branch's delay slot is safely in the pipeline.

## Interface
Parameters:
- `GHR_W`, default 8: global history width, matching the PHT's `GHR` and `Recover_GHR` fields.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high.
- `ex_valid`, in, 1: EX holds a control-flow instruction, or an instruction the predictor flagged as one (`ex_pred.PC_Vaild`).
- `ex_pc`, in, 32: PC of that instruction.
- `ex_type`, in, `BranchType`: actual decoded type (`None`, `Branch`, `Call`, `Return`, `Jump`).
- `ex_taken`, in, 1: actual direction. It is forced to 1 for `Call`, `Return` and `Jump`.
- `ex_target`, in, 32: actual taken target.
- `ex_pred`, in, `Predict_Branch_S`: prediction packet captured at fetch.
- `ds_present`, in, 1: the delay-slot instruction (`ex_pc+4`) currently occupies ID or later.
- `stall`, in, 1: pipeline hold.
- `flush`, in, 1: exception/eret flush. It has priority over everything except reset.
- `busy`, out, 1: EX must stall. Asserted while state is `WAIT_DS`.
- `Update_Predict`, out, `Update_Branch_S`: training and redirect packet, registered.

## Operation
- Predicted taken:
  - `pt = ex_pred.PC_Vaild && (ex_pred.BranchType != Branch || sel_ctr >= 2)`.
  - `sel_ctr` is `GHR_Counter` when `CPHT` is 0 or 1, and `TBT_Counter` otherwise.
- Correct next PC: `ctgt = ex_taken ? ex_target : ex_pc + 8` (32-bit, wraps modulo 2^32).
- Misprediction `mp` is true when any of these holds:
  - `ex_type == None && ex_pred.PC_Vaild` (false BTB hit; `ctgt = ex_pc+8`).
  - `ex_type != None && pt != ex_taken`.
  - `ex_type != None && ex_taken && ex_pred.Target != ex_target`.
- Packet fields:
  - `PC_Vaild = 1`
  - `Update_PC = ex_pc`
  - `Update_Target = ctgt`
  - `PC_Taken = ex_taken`
  - `BranchType = ex_type`
  - `Predict_BranchType = ex_pred.BranchType`
  - `Update_Location = ex_pc[2]`
  - `TBT_Counter`, `GHR_Counter`, `CPHT`, `GHR`: copied from `ex_pred`. The PHT saturates them.
  - `Recover_GHR = {ex_pred.Recover_GHR[GHR_W-2:0], ex_taken}`
  - `PC_MissPredict = mp`
  - `Update_True_PC = mp`
- FSM states:
  - `IDLE`, when `ex_valid && !stall`:
    - `!mp`: register the training packet. Stay in `IDLE`.
    - `mp && ds_present`: register the packet with redirect. Stay in `IDLE`.
    - `mp && !ds_present`: latch the packet into `pend`, go to `WAIT_DS`, emit nothing.
  - `WAIT_DS`:
    - `busy = 1`; EX input is ignored.
    - On `ds_present`: emit `pend`, go to `IDLE`.
- Stall and flush:
  - `stall` in `IDLE`: no packet is emitted.
  - `stall` does not block `WAIT_DS`; it completes on `ds_present`.
  - `flush`: next cycle `Update_Predict` is all-zero, state is `IDLE`, `pend` is discarded, `busy = 0`.

## Timing
- Reset: `Update_Predict` all-zero (`PC_Vaild=0`, `BranchType=None`), state `IDLE`, `busy=0`. Reset takes effect immediately and asynchronously; any pending redirect is dropped.
- Latency: the packet is visible exactly 1 cycle after the qualifying EX cycle, or 1 cycle after `ds_present` rises in `WAIT_DS`.
- `Update_Predict.PC_Vaild` is a single-cycle pulse. It is never held across cycles, even if `stall` stays high.
- Back-to-back resolutions in `IDLE` yield back-to-back pulses. No buffering beyond the single `pend` entry.
- `busy` is combinational from state only: high from the cycle after entering `WAIT_DS` through the cycle `ds_present` is seen.
- `flush` in the same cycle as `ds_present` in `WAIT_DS`: the flush wins and no packet is emitted.

## Test plan
- Taken conditional hit:
  - Stimulus: `ex_pc=BFC00010`, `ex_type=Branch`, `ex_taken=1`, `ex_target=BFC00100`, prediction agrees (`ex_pred.Target=BFC00100`, counter 3), `ds_present=1`.
  - Response: next cycle `PC_Vaild=1`, `PC_MissPredict=0`, `Update_Location=0`, `Update_Target=BFC00100`.
- Direction mispredict:
  - Stimulus: `ex_pc=BFC00014`, predicted counter 1, `ex_taken=1`, `ex_target=BFC00200`, `ds_present=1`.
  - Response: `PC_MissPredict=1`, `Update_True_PC=1`, `Update_Target=BFC00200`, `Update_Location=1`.
- Delay slot absent:
  - Stimulus: the same mispredict with `ds_present=0` for 3 cycles, then 1.
  - Response: `busy=1` for 3 cycles; the packet appears the cycle after `ds_present`; no packet before.
- False BTB hit:
  - Stimulus: `ex_type=None`, `ex_pred.PC_Vaild=1`, `ex_pc=BFC00020`.
  - Response: `PC_MissPredict=1`, `Update_Target=BFC00028`.
- History and wrap:
  - Stimulus: `Recover_GHR=8'hA5`, `ex_taken=0`, not-taken branch at `ex_pc=FFFFFFFC`.
  - Response: `Recover_GHR=8'h4A`, `Update_Target=00000004`.
- Flush and reset while waiting:
  - Stimulus: `flush` in `WAIT_DS`, coincident with `ds_present`.
  - Response: no packet, state `IDLE`.
  - Stimulus: asynchronous `reset` mid-`WAIT_DS`.
  - Response: `busy=0` and `Update_Predict` zero immediately.
